// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the payload layouts of the IF/ID and ID/EX registers.
package pipeline_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned RT_W        = 5;
  localparam int unsigned CTRL_W      = 12;
  localparam int unsigned MEMREAD_BIT = 3;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [RT_W-1:0]   rt;
    logic              valid;
  } id_ex_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: reset or clear forces zero, otherwise load when enabled.
module pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         En,
  input  logic         Clr,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  logic [W-1:0] data_q;

  // Reset has priority, then squash, then capture.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      data_q <= '0;
    end else if (Clr) begin
      data_q <= '0;
    end else if (En) begin
      data_q <= D;
    end
  end

  assign Q = data_q;

endmodule

// File: rtl/stall_bubble_pipe_ctrl.sv
// Front-end pipeline control: owns PC, IF/ID and ID/EX, applies stall/bubble/flush,
// and keeps saturating stall statistics plus a stuck-stall watchdog.
module stall_bubble_pipe_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC,
  parameter int unsigned MAX_STALL = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              PCWre,
  input  logic              IF_ID_Wre,
  input  logic              ControlSrc,
  input  logic              Flush,
  input  logic [31:0]       NextPC,
  input  logic [31:0]       IF_Instr,
  input  logic [31:0]       IF_PC4,
  input  logic [CTRL_W-1:0] ID_Ctrl,
  input  logic [4:0]        ID_rt,
  output logic [31:0]       PC,
  output logic [31:0]       ID_Instr,
  output logic [31:0]       ID_PC4,
  output logic              ID_Valid,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [4:0]        EX_rt,
  output logic              EX_MemRead,
  output logic              EX_Valid,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  BubbleCount,
  output logic              StallErr
);

  localparam int unsigned    RUN_W   = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);

  logic [31:0]      pc_q, pc_d;
  if_id_t           if_id_d, if_id_q;
  id_ex_t           id_ex_d, id_ex_q;
  logic             id_ex_clr;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             stall_err_q, stall_err_d;

  // PC next value: a flush redirects even when the front end is stalled.
  always_comb begin
    pc_d = pc_q;
    if (Flush || PCWre) begin
      pc_d = NextPC;
    end
  end

  // PC register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID payload: a captured fetch is always a real instruction.
  always_comb begin
    if_id_d       = '0;
    if_id_d.instr = IF_Instr;
    if_id_d.pc4   = IF_PC4;
    if_id_d.valid = 1'b1;
  end

  pipe_reg #(.W($bits(if_id_t))) u_if_id (
    .CLK   (CLK),
    .Reset (Reset),
    .En    (IF_ID_Wre),
    .Clr   (Flush),
    .D     (if_id_d),
    .Q     (if_id_q)
  );

  // ID/EX payload: an empty ID slot must not leak control bits into EX.
  always_comb begin
    id_ex_d       = '0;
    id_ex_d.ctrl  = if_id_q.valid ? ID_Ctrl : '0;
    id_ex_d.rt    = ID_rt;
    id_ex_d.valid = if_id_q.valid;
    id_ex_clr     = Flush | ControlSrc;
  end

  pipe_reg #(.W($bits(id_ex_t))) u_id_ex (
    .CLK   (CLK),
    .Reset (Reset),
    .En    (1'b1),
    .Clr   (id_ex_clr),
    .D     (id_ex_d),
    .Q     (id_ex_q)
  );

  // Statistics and watchdog next state; a flush cycle is not counted as a stall or bubble.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    run_d        = run_q;
    if (!PCWre && !Flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ControlSrc && !Flush && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if (PCWre || Flush) begin
      run_d = '0;
    end else if (run_q != RUN_MAX) begin
      run_d = run_q + RUN_W'(1);
    end
    stall_err_d = stall_err_q | (run_d > RUN_LIM);
  end

  // Statistics and watchdog registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      run_q        <= '0;
      stall_err_q  <= 1'b0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      run_q        <= run_d;
      stall_err_q  <= stall_err_d;
    end
  end

  assign PC          = pc_q;
  assign ID_Instr    = if_id_q.valid ? if_id_q.instr : NOP_INSTR;
  assign ID_PC4      = if_id_q.pc4;
  assign ID_Valid    = if_id_q.valid;
  assign EX_Ctrl     = id_ex_q.ctrl;
  assign EX_rt       = id_ex_q.rt;
  assign EX_MemRead  = id_ex_q.ctrl[MEMREAD_BIT];
  assign EX_Valid    = id_ex_q.valid;
  assign StallCount  = stall_cnt_q;
  assign BubbleCount = bubble_cnt_q;
  assign StallErr    = stall_err_q;

endmodule

// File: tb/tb_stall_bubble_pipe_ctrl.sv
// Bench for stall_bubble_pipe_ctrl: directed vector table, randomized run against a
// behavioural model, reset-with-X sequence and counter saturation.
module tb_stall_bubble_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst, pcwre, wre, csrc, flush;
  logic [31:0] npc, ins, pc4;
  logic [11:0] ctl;
  logic [4:0]  rt;
  logic [31:0] o_pc, o_instr, o_pc4;
  logic        o_idv, o_mr, o_exv, o_err;
  logic [11:0] o_ctrl;
  logic [4:0]  o_rt;
  logic [15:0] o_sc, o_bc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stall_bubble_pipe_ctrl dut (
    .CLK         (clk),
    .Reset       (rst),
    .PCWre       (pcwre),
    .IF_ID_Wre   (wre),
    .ControlSrc  (csrc),
    .Flush       (flush),
    .NextPC      (npc),
    .IF_Instr    (ins),
    .IF_PC4      (pc4),
    .ID_Ctrl     (ctl),
    .ID_rt       (rt),
    .PC          (o_pc),
    .ID_Instr    (o_instr),
    .ID_PC4      (o_pc4),
    .ID_Valid    (o_idv),
    .EX_Ctrl     (o_ctrl),
    .EX_rt       (o_rt),
    .EX_MemRead  (o_mr),
    .EX_Valid    (o_exv),
    .StallCount  (o_sc),
    .BubbleCount (o_bc),
    .StallErr    (o_err)
  );

  typedef struct {
    logic        r, p, w, c, f;
    logic [31:0] npc, ins, pc4;
    logic [11:0] ctl;
    logic [4:0]  rt;
    logic [31:0] e_pc, e_ins, e_pc4;
    logic        e_idv;
    logic [11:0] e_ctl;
    logic [4:0]  e_rt;
    logic        e_mr, e_exv;
    logic [15:0] e_sc, e_bc;
    logic        e_err;
  } vec_t;

  vec_t vecs[15];

  // Behavioural model state
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_idv, m_exv, m_err;
  logic [11:0] m_ctl;
  logic [4:0]  m_rt;
  int          m_sc, m_bc, m_run;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic p, input logic w, input logic c, input logic f,
                       input logic [31:0] a_npc, input logic [31:0] a_ins, input logic [31:0] a_pc4,
                       input logic [11:0] a_ctl, input logic [4:0] a_rt);
    rst = r; pcwre = p; wre = w; csrc = c; flush = f;
    npc = a_npc; ins = a_ins; pc4 = a_pc4; ctl = a_ctl; rt = a_rt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of one clock edge, built directly from the pipeline rules.
  task automatic m_step();
    if (rst) begin
      m_pc = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0; m_idv = 1'b0;
      m_ctl = 12'h0; m_rt = 5'h0; m_exv = 1'b0;
      m_sc = 0; m_bc = 0; m_run = 0; m_err = 1'b0;
    end else begin
      if (flush || csrc) begin
        m_ctl = 12'h0; m_rt = 5'h0; m_exv = 1'b0;
      end else begin
        m_ctl = m_idv ? ctl : 12'h0;
        m_rt  = rt;
        m_exv = m_idv;
      end
      if (flush) begin
        m_ins = 32'h0; m_pc4 = 32'h0; m_idv = 1'b0;
      end else if (wre) begin
        m_ins = ins; m_pc4 = pc4; m_idv = 1'b1;
      end
      if (flush || pcwre) m_pc = npc;
      if (!pcwre && !flush && m_sc < 65535) m_sc++;
      if (csrc && !flush && m_bc < 65535) m_bc++;
      if (pcwre || flush) m_run = 0;
      else if (m_run < 5) m_run++;
      if (m_run > 4) m_err = 1'b1;
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".PC"}, o_pc, m_pc);
    chk({tag, ".ID_Instr"}, o_instr, m_ins);
    chk({tag, ".ID_PC4"}, o_pc4, m_pc4);
    chk({tag, ".ID_Valid"}, 32'(o_idv), 32'(m_idv));
    chk({tag, ".EX_Ctrl"}, 32'(o_ctrl), 32'(m_ctl));
    chk({tag, ".EX_rt"}, 32'(o_rt), 32'(m_rt));
    chk({tag, ".EX_MemRead"}, 32'(o_mr), 32'(m_ctl[3]));
    chk({tag, ".EX_Valid"}, 32'(o_exv), 32'(m_exv));
    chk({tag, ".StallCount"}, 32'(o_sc), 32'(m_sc));
    chk({tag, ".BubbleCount"}, 32'(o_bc), 32'(m_bc));
    chk({tag, ".StallErr"}, 32'(o_err), 32'(m_err));
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0, 5'h0);

    // Directed table: inputs for one edge, then expected outputs after it.
    vecs[0]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 32'h40, 32'h0, 32'h0, 12'h000, 5'd0,
                 32'h0, 32'h0, 32'h0, 1'b0, 12'h000, 5'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h40, 32'h1111_0001, 32'h44, 12'h008, 5'd5,
                 32'h40, 32'h1111_0001, 32'h44, 1'b1, 12'h000, 5'd5, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h44, 32'h2222_0002, 32'h48, 12'h008, 5'd7,
                 32'h44, 32'h2222_0002, 32'h48, 1'b1, 12'h008, 5'd7, 1'b1, 1'b1, 16'd0, 16'd0, 1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h48, 32'h3333_0003, 32'h4C, 12'hFFF, 5'd31,
                 32'h44, 32'h2222_0002, 32'h48, 1'b1, 12'h000, 5'd0, 1'b0, 1'b0, 16'd1, 16'd1, 1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h48, 32'h3333_0003, 32'h4C, 12'h00F, 5'd9,
                 32'h48, 32'h3333_0003, 32'h4C, 1'b1, 12'h00F, 5'd9, 1'b1, 1'b1, 16'd1, 16'd1, 1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b1, 32'h100, 32'h5555_0005, 32'h1234, 12'hABC, 5'd4,
                 32'h100, 32'h0, 32'h0, 1'b0, 12'h000, 5'd0, 1'b0, 1'b0, 16'd1, 16'd1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      vecs[6+i] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h200, 32'hDEAD, 32'hBEEF, 12'hFFF, 5'd3,
                    32'h100, 32'h0, 32'h0, 1'b0, 12'h000, 5'd3, 1'b0, 1'b0,
                    16'(2 + i), 16'd1, (i == 4)};
    end
    vecs[11] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h104, 32'h4444_0004, 32'h108, 12'h00A, 5'd0,
                 32'h104, 32'h4444_0004, 32'h108, 1'b1, 12'h000, 5'd0, 1'b0, 1'b0, 16'd6, 16'd1, 1'b1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h200, 32'h7777, 32'h8888, 12'h008, 5'd2,
                 32'h104, 32'h4444_0004, 32'h108, 1'b1, 12'h000, 5'd0, 1'b0, 1'b0, 16'd7, 16'd2, 1'b1};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 32'h300, 32'h9999, 32'hAAAA, 12'hFFF, 5'd1,
                 32'h0, 32'h0, 32'h0, 1'b0, 12'h000, 5'd0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0};
    vecs[14] = '{1'b0,1'b1,1'b1,1'b0,1'b0, 32'h40, 32'h6, 32'h44, 12'h008, 5'd1,
                 32'h40, 32'h6, 32'h44, 1'b1, 12'h000, 5'd1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(vecs[i].r, vecs[i].p, vecs[i].w, vecs[i].c, vecs[i].f,
            vecs[i].npc, vecs[i].ins, vecs[i].pc4, vecs[i].ctl, vecs[i].rt);
      tick();
      chk({t, ".PC"}, o_pc, vecs[i].e_pc);
      chk({t, ".ID_Instr"}, o_instr, vecs[i].e_ins);
      chk({t, ".ID_PC4"}, o_pc4, vecs[i].e_pc4);
      chk({t, ".ID_Valid"}, 32'(o_idv), 32'(vecs[i].e_idv));
      chk({t, ".EX_Ctrl"}, 32'(o_ctrl), 32'(vecs[i].e_ctl));
      chk({t, ".EX_rt"}, 32'(o_rt), 32'(vecs[i].e_rt));
      chk({t, ".EX_MemRead"}, 32'(o_mr), 32'(vecs[i].e_mr));
      chk({t, ".EX_Valid"}, 32'(o_exv), 32'(vecs[i].e_exv));
      chk({t, ".StallCount"}, 32'(o_sc), 32'(vecs[i].e_sc));
      chk({t, ".BubbleCount"}, 32'(o_bc), 32'(vecs[i].e_bc));
      chk({t, ".StallErr"}, 32'(o_err), 32'(vecs[i].e_err));
    end

    // Randomized run against the model, starting from reset.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0, 5'h0);
    m_step();
    tick();
    chk_model("rnd_reset");
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            $urandom, $urandom, $urandom, 12'($urandom), 5'($urandom));
      if ($urandom_range(0, 199) == 0) begin
        for (int k = 0; k < 6; k++) begin
          m_step();
          tick();
          chk_model($sformatf("rnd%0d_run%0d", i, k));
          pcwre = 1'b0; flush = 1'b0; rst = 1'b0;
        end
      end
      m_step();
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    // Reset arriving mid-stall with unknown controls.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h1, 32'h2, 12'h008, 5'd6);
    tick();
    rst = 1'b1; csrc = 1'bx; flush = 1'bx; wre = 1'bx; npc = 32'h40;
    tick();
    chk("xrst.known", 32'($isunknown({o_pc, o_instr, o_pc4, o_idv, o_ctrl, o_rt, o_mr,
                                     o_exv, o_sc, o_bc, o_err})), 32'h0);
    chk("xrst.PC", o_pc, 32'h0);
    chk("xrst.ID_Valid", 32'(o_idv), 32'h0);
    chk("xrst.EX_Valid", 32'(o_exv), 32'h0);
    chk("xrst.EX_MemRead", 32'(o_mr), 32'h0);
    chk("xrst.StallCount", 32'(o_sc), 32'h0);
    chk("xrst.BubbleCount", 32'(o_bc), 32'h0);
    chk("xrst.StallErr", 32'(o_err), 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 32'hC0DE, 32'h84, 12'h0, 5'd0);
    tick();
    chk("xrst.release_PC", o_pc, 32'h80);

    // Saturation of the stall counter.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0, 5'd0);
    for (int n = 1; n <= 65536; n++) begin
      tick();
      if (n == 65534) chk("sat.pre", 32'(o_sc), 32'h0000_FFFE);
      if (n == 65535) chk("sat.hit", 32'(o_sc), 32'h0000_FFFF);
    end
    chk("sat.hold", 32'(o_sc), 32'h0000_FFFF);
    chk("sat.err", 32'(o_err), 32'h1);
    chk("sat.bubble", 32'(o_bc), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
